// File: rtl/addertree_acc_ctrl.sv
// addertree_acc_ctrl: issue sequencer and accumulation owner for the stage-2 adder tree and final adder.
// Overflow tracking is built only when ADDERTREE_CTRL_OVF_EN is defined; otherwise out_ovf is tied low.
module addertree_acc_ctrl #(
  parameter int ACC_W = 13,
  parameter int SUM_W = 20,
  parameter int LAT   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             tree_en,
  output logic [ACC_W:1]   pre_output,
  input  logic [SUM_W-1:0] sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             busy
);
  localparam int LAT_W = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_OUT} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;
  logic [LAT_W-1:0] r_lat;
  logic             r_last;
  logic [ACC_W:1]   r_pre;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_out_data;
  logic [CNT_W-1:0] r_out_count;
  logic             w_sample;
  logic             w_accept;

  assign w_sample   = (r_state == S_WAIT) && (r_lat == LAT_W'(1));
  assign w_accept   = r_out_valid & out_ready;

  assign in_ready   = r_in_ready;
  assign tree_en    = in_valid & r_in_ready;
  assign pre_output = r_pre;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_count  = r_out_count;
  assign busy       = r_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_lat       <= '0;
      r_last      <= 1'b0;
      r_pre       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (in_valid) begin
            r_state    <= S_WAIT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_lat      <= LAT_W'(LAT);
            r_last     <= in_last;
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          // sum_in is only trusted on the edge where the latency count expires
          if (w_sample) begin
            if (r_last) begin
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
              r_out_data  <= sum_in;
              r_out_count <= r_cnt;
            end else begin
              r_state    <= S_ACC;
              r_in_ready <= 1'b1;
              r_pre      <= sum_in[ACC_W-1:0];
            end
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        S_OUT: begin
          if (w_accept) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_pre       <= '0;
            r_cnt       <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ADDERTREE_CTRL_OVF_EN
  logic r_ovf;
  logic r_out_ovf;
  logic w_ovf_hit;

  // bits above the feedback width are dropped when fed back, so any of them set is a loss
  assign w_ovf_hit = |sum_in[SUM_W-1:ACC_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf     <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_sample) begin
      if (r_last)         r_out_ovf <= r_ovf;
      else if (w_ovf_hit) r_ovf     <= 1'b1;
    end
  end

  assign out_ovf = r_out_ovf;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addertree_acc_ctrl.sv
// Self-checking bench for addertree_acc_ctrl: directed groups then random groups against a group-level model.
module tb_addertree_acc_ctrl;
  localparam int LAT   = 2;
  localparam int ACC_W = 13;
  localparam int SUM_W = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, in_valid, in_last, out_ready;
  logic [SUM_W-1:0] sum_in;

  logic             a_in_ready, a_tree_en, a_out_valid, a_out_ovf, a_busy;
  logic [ACC_W:1]   a_pre;
  logic [SUM_W-1:0] a_out_data;
  logic [7:0]       a_out_count;

  logic             b_in_ready, b_tree_en, b_out_valid, b_out_ovf, b_busy;
  logic [ACC_W:1]   b_pre;
  logic [SUM_W-1:0] b_out_data;
  logic [1:0]       b_out_count;

  int total = 0;
  int bad   = 0;

  addertree_acc_ctrl #(.ACC_W(ACC_W), .SUM_W(SUM_W), .LAT(LAT), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(a_in_ready), .tree_en(a_tree_en), .pre_output(a_pre), .sum_in(sum_in),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_count(a_out_count), .out_ovf(a_out_ovf), .busy(a_busy)
  );

  addertree_acc_ctrl #(.ACC_W(ACC_W), .SUM_W(SUM_W), .LAT(LAT), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(b_in_ready), .tree_en(b_tree_en), .pre_output(b_pre), .sum_in(sum_in),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_count(b_out_count), .out_ovf(b_out_ovf), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int n, input int w);
    int m;
    m = (1 << w) - 1;
    return (n > m) ? m : n;
  endfunction

  // group-level model: truncation flag is any non-last sum with bits above the feedback width
  function automatic logic model_ovf(input logic [SUM_W-1:0] sums [$]);
    logic f;
    f = 1'b0;
`ifdef ADDERTREE_CTRL_OVF_EN
    for (int i = 0; i < sums.size() - 1; i++)
      if ((sums[i] >> ACC_W) != 0) f = 1'b1;
`endif
    return f;
  endfunction

  // issue one term and ride out the tree latency; sum_in is valid only just before the sample edge
  task automatic issue_term(input logic [SUM_W-1:0] s, input logic last);
    in_valid = 1'b1;
    in_last  = last;
    #1;
    chk("issue_tree_en", a_tree_en, 1);
    tick;
    for (int k = 0; k < LAT; k++) begin
      chk("wait_in_ready", a_in_ready, 0);
      chk("wait_tree_en", a_tree_en, 0);
      chk("wait_busy", a_busy, 1);
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      sum_in   = (k == LAT - 1) ? s : SUM_W'($urandom);
      tick;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    sum_in   = SUM_W'($urandom);
  endtask

  task automatic do_group(input logic [SUM_W-1:0] sums [$], input int stall);
    logic [ACC_W-1:0] exp_pre;
    logic [SUM_W-1:0] last_sum;
    logic             exp_ovf;
    int               n, idle;
    n        = sums.size();
    exp_pre  = '0;
    exp_ovf  = model_ovf(sums);
    last_sum = sums[n-1];
    for (int i = 0; i < n; i++) begin
      chk("pre_in_ready", a_in_ready, 1);
      chk("pre_busy", a_busy, (i != 0));
      chk("pre_pre_output", a_pre, exp_pre);
      issue_term(sums[i], (i == n - 1));
      if (i < n - 1) begin
        exp_pre = sums[i][ACC_W-1:0];
        idle = $urandom_range(0, 2);
        for (int g = 0; g <= idle; g++) begin
          chk("acc_in_ready", a_in_ready, 1);
          chk("acc_out_valid", a_out_valid, 0);
          chk("acc_pre_output", a_pre, exp_pre);
          if (g < idle) tick;
        end
      end
    end
    in_valid  = 1'b1;
    in_last   = 1'($urandom);
    out_ready = 1'b0;
    #1;
    for (int c = 0; c <= stall; c++) begin
      chk("out_valid", a_out_valid, 1);
      chk("out_data", a_out_data, last_sum);
      chk("out_count", a_out_count, sat(n, 8));
      chk("out_count_sat", b_out_count, sat(n, 2));
      chk("out_ovf", a_out_ovf, exp_ovf);
      chk("out_in_ready", a_in_ready, 0);
      chk("out_tree_en", a_tree_en, 0);
      chk("out_busy", a_busy, 1);
      chk("out_pre_output", a_pre, exp_pre);
      if (c == 0) begin
        chk("b_out_valid", b_out_valid, 1);
        chk("b_out_data", b_out_data, last_sum);
        chk("b_out_ovf", b_out_ovf, exp_ovf);
        chk("b_in_ready", b_in_ready, 0);
        chk("b_tree_en", b_tree_en, 0);
        chk("b_busy", b_busy, 1);
        chk("b_pre_output", b_pre, exp_pre);
      end
      if (c == stall) out_ready = 1'b1;
      tick;
    end
    out_ready = 1'b0;
    chk("post_out_valid", a_out_valid, 0);
    chk("post_in_ready", a_in_ready, 1);
    chk("post_tree_en", a_tree_en, 1);
    chk("post_busy", a_busy, 0);
    chk("post_pre_output", a_pre, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, a_in_ready, 1);
    chk({tag, "_tree_en"}, a_tree_en, 0);
    chk({tag, "_pre_output"}, a_pre, 0);
    chk({tag, "_out_valid"}, a_out_valid, 0);
    chk({tag, "_out_data"}, a_out_data, 0);
    chk({tag, "_out_count"}, a_out_count, 0);
    chk({tag, "_out_ovf"}, a_out_ovf, 0);
    chk({tag, "_busy"}, a_busy, 0);
  endtask

  initial begin
    logic [SUM_W-1:0] q [$];
    logic [SUM_W-1:0] s;
    int               n;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    sum_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("rst");
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    chk_reset_values("idle");

    q = {}; q.push_back(20'h00123);
    do_group(q, 0);

    q = {}; q.push_back(20'h00005); q.push_back(20'h0000C); q.push_back(20'h0001F);
    do_group(q, 0);

    q = {}; q.push_back(20'h00040); q.push_back(20'h00777);
    do_group(q, 5);

    q = {}; q.push_back(20'h02000); q.push_back(20'h00010);
    do_group(q, 1);

    q = {}; for (int i = 0; i < 5; i++) q.push_back(SUM_W'(i + 1));
    do_group(q, 0);

    // abort a group mid-WAIT after one term has already been folded into pre_output
    issue_term(20'h00ABC, 1'b0);
    chk("abort_pre_output", a_pre, 13'h0ABC);
    in_valid = 1'b1;
    in_last  = 1'b0;
    tick;
    in_valid = 1'b0;
    tick;
    chk("abort_busy", a_busy, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_values("abort");
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    q = {}; q.push_back(20'h00321);
    do_group(q, 0);

    for (int g = 0; g < 20; g++) begin
      n = $urandom_range(1, 6);
      q = {};
      for (int i = 0; i < n; i++) begin
        s = SUM_W'($urandom);
        if ((i < n - 1) && ($urandom_range(0, 3) != 0)) s = s & 20'h01FFF;
        q.push_back(s);
      end
      do_group(q, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
